// File: rtl/tl_inflight_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tl_inflight_monitor
// Purpose  : Passive TileLink-UL protocol monitor. Tracks the outstanding
//            request per source ID, checks the A/D handshakes and bursts,
//            runs a D-channel progress watchdog, and reports the
//            lowest-numbered error seen in each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tl_inflight_monitor #(
  parameter int SOURCE_BITS = 3,
  parameter int ADDR_BITS   = 32,
  parameter int BEAT_LOG2   = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     a_valid,
  input  logic                     a_ready,
  input  logic [2:0]               a_opcode,
  input  logic [2:0]               a_param,
  input  logic [2:0]               a_size,
  input  logic [SOURCE_BITS-1:0]   a_source,
  input  logic [ADDR_BITS-1:0]     a_address,
  input  logic [(1<<BEAT_LOG2)-1:0] a_mask,
  input  logic                     d_valid,
  input  logic                     d_ready,
  input  logic [2:0]               d_opcode,
  input  logic [2:0]               d_size,
  input  logic [SOURCE_BITS-1:0]   d_source,
  input  logic                     d_denied,
  input  logic                     d_corrupt,
  output logic                     err_valid,
  output logic [3:0]               err_code,
  output logic [SOURCE_BITS-1:0]   err_source,
  output logic                     err_sticky,
  output logic [7:0]               err_count,
  output logic [SOURCE_BITS:0]     inflight_count
);
  localparam int NUM_IDS   = 1 << SOURCE_BITS;
  localparam int MASK_BITS = 1 << BEAT_LOG2;
  localparam int WD_BITS   = $clog2(TIMEOUT + 1);
  localparam logic [2:0] BEAT_SIZE   = 3'(BEAT_LOG2);
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  // Denied/corrupt responses are legal, so these flags are observed but unused.
  logic unused_d_flags;
  assign unused_d_flags = d_denied ^ d_corrupt;

  // Inflight table, burst trackers, stall capture, watchdog, outputs.
  logic [NUM_IDS-1:0]        tbl_valid_q, tbl_valid_d;
  logic [NUM_IDS-1:0]        tbl_get_q, tbl_get_d;
  logic [NUM_IDS-1:0][2:0]   tbl_size_q, tbl_size_d;
  logic [7:0]                a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  logic [2:0]                a_op_q, a_size_q, d_op_q, d_size_q;
  logic [SOURCE_BITS-1:0]    a_src_q, d_src_q;
  logic [ADDR_BITS-1:0]      a_addr_q;
  logic                      st_q;
  logic [2:0]                st_op_q, st_param_q, st_size_q;
  logic [SOURCE_BITS-1:0]    st_src_q;
  logic [ADDR_BITS-1:0]      st_addr_q;
  logic [MASK_BITS-1:0]      st_mask_q;
  logic [WD_BITS-1:0]        wd_cnt_q, wd_cnt_d;
  logic                      wd_fired_q, wd_fired_d;
  logic                      err_valid_q, err_valid_d, err_sticky_q;
  logic [3:0]                err_code_q, err_code_d;
  logic [SOURCE_BITS-1:0]    err_source_q, err_source_d;
  logic [7:0]                err_count_q, err_count_d;
  logic [SOURCE_BITS:0]      inflight_q, inflight_d;

  // Channel decode shared by the checks below.
  logic                      a_fire, a_first, a_is_put, a_legal;
  logic                      d_fire, d_first, d_hit, d_multi;
  logic [7:0]                a_beats_m1, d_beats_m1;
  logic                      d_clear;
  logic [SOURCE_BITS-1:0]    d_clr_src;
  logic                      e_a_op, e_a_align, e_a_busy, e_a_unstable, e_a_burst;
  logic                      e_d_src, e_d_op, e_d_size, e_d_burst, e_timeout;

  assign a_fire     = a_valid & a_ready;
  assign a_first    = (a_cnt_q == 8'd0);
  assign a_is_put   = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART);
  assign a_legal    = a_is_put | (a_opcode == OP_GET);
  assign a_beats_m1 = (8'd1 << (a_size - BEAT_SIZE)) - 8'd1;
  assign d_fire     = d_valid & d_ready;
  assign d_first    = (d_cnt_q == 8'd0);
  assign d_hit      = tbl_valid_q[d_source];
  assign d_multi    = (d_opcode == OP_ACK_DATA) && (d_size > BEAT_SIZE);
  assign d_beats_m1 = (8'd1 << (d_size - BEAT_SIZE)) - 8'd1;

  // A-channel checks and A beat counter; only a live channel is examined.
  always_comb begin
    e_a_op       = a_valid & ~a_legal;
    e_a_align    = a_valid & (|(a_address & ~({ADDR_BITS{1'b1}} << a_size)));
    e_a_busy     = a_fire & a_first & tbl_valid_q[a_source] &
                   ~(d_clear & (d_clr_src == a_source));
    e_a_unstable = st_q & (~a_valid | (a_opcode != st_op_q) | (a_param != st_param_q) |
                   (a_size != st_size_q) | (a_source != st_src_q) |
                   (a_address != st_addr_q) | (a_mask != st_mask_q));
    e_a_burst    = a_fire & ~a_first & ((a_opcode != a_op_q) | (a_size != a_size_q) |
                   (a_source != a_src_q) | (a_address != a_addr_q));
    a_cnt_d      = a_cnt_q;
    if (a_fire) begin
      if (!a_first)
        a_cnt_d = a_cnt_q - 8'd1;
      else if (a_is_put && (a_size > BEAT_SIZE))
        a_cnt_d = a_beats_m1;
    end
  end

  // D-channel checks, D beat counter and the table-clear request on the last beat.
  always_comb begin
    d_cnt_d   = d_cnt_q;
    d_clear   = 1'b0;
    d_clr_src = d_source;
    if (d_fire) begin
      if (!d_first) begin
        // Later beats retire the ID that opened the burst.
        d_cnt_d   = d_cnt_q - 8'd1;
        d_clr_src = d_src_q;
        d_clear   = (d_cnt_q == 8'd1);
      end else if (d_hit) begin
        if (d_multi) d_cnt_d = d_beats_m1;
        else         d_clear = 1'b1;
      end
    end
    e_d_src   = d_fire & ~d_hit;
    e_d_op    = d_fire & d_hit &
                (d_opcode != (tbl_get_q[d_source] ? OP_ACK_DATA : OP_ACK));
    e_d_size  = d_fire & d_hit & (d_size != tbl_size_q[d_source]);
    e_d_burst = d_fire & ~d_first & ((d_opcode != d_op_q) | (d_size != d_size_q) |
                (d_source != d_src_q));
  end

  // Table update: clear first so a same-ID reissue in the same cycle stays valid.
  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_get_d   = tbl_get_q;
    tbl_size_d  = tbl_size_q;
    if (d_clear) tbl_valid_d[d_clr_src] = 1'b0;
    if (a_fire && a_first) begin
      tbl_valid_d[a_source] = 1'b1;
      tbl_get_d[a_source]   = (a_opcode == OP_GET);
      tbl_size_d[a_source]  = a_size;
    end
    inflight_d = '0;
    for (int i = 0; i < NUM_IDS; i++)
      inflight_d = inflight_d + {{SOURCE_BITS{1'b0}}, tbl_valid_d[i]};
  end

  // Watchdog: counts stalled-D cycles while work is outstanding, fires once.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    wd_fired_d = wd_fired_q;
    e_timeout  = 1'b0;
    if (d_fire || (inflight_q == '0)) begin
      wd_cnt_d   = '0;
      wd_fired_d = 1'b0;
    end else if (!wd_fired_q) begin
      if (wd_cnt_q == WD_BITS'(TIMEOUT - 1)) begin
        e_timeout  = 1'b1;
        wd_fired_d = 1'b1;
        wd_cnt_d   = WD_BITS'(TIMEOUT);
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  // Report the lowest-numbered error and its source ID.
  always_comb begin
    err_valid_d  = 1'b1;
    err_code_d   = 4'd0;
    err_source_d = a_source;
    if      (e_a_op)       err_code_d = 4'd1;
    else if (e_a_align)    err_code_d = 4'd2;
    else if (e_a_busy)     err_code_d = 4'd3;
    else if (e_a_unstable) err_code_d = 4'd4;
    else if (e_a_burst)    err_code_d = 4'd5;
    else begin
      err_source_d = d_source;
      if      (e_d_src)   err_code_d = 4'd6;
      else if (e_d_op)    err_code_d = 4'd7;
      else if (e_d_size)  err_code_d = 4'd8;
      else if (e_d_burst) err_code_d = 4'd9;
      else begin
        err_source_d = '0;
        if (e_timeout) err_code_d = 4'd10;
        else           err_valid_d = 1'b0;
      end
    end
    err_count_d = err_count_q;
    if (err_valid_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tbl_valid_q  <= '0;
      tbl_get_q    <= '0;
      tbl_size_q   <= '0;
      a_cnt_q      <= '0;
      d_cnt_q      <= '0;
      a_op_q       <= '0;
      a_size_q     <= '0;
      a_src_q      <= '0;
      a_addr_q     <= '0;
      d_op_q       <= '0;
      d_size_q     <= '0;
      d_src_q      <= '0;
      st_q         <= 1'b0;
      st_op_q      <= '0;
      st_param_q   <= '0;
      st_size_q    <= '0;
      st_src_q     <= '0;
      st_addr_q    <= '0;
      st_mask_q    <= '0;
      wd_cnt_q     <= '0;
      wd_fired_q   <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_source_q <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      inflight_q   <= '0;
    end else begin
      tbl_valid_q  <= tbl_valid_d;
      tbl_get_q    <= tbl_get_d;
      tbl_size_q   <= tbl_size_d;
      a_cnt_q      <= a_cnt_d;
      d_cnt_q      <= d_cnt_d;
      if (a_fire && a_first) begin
        a_op_q   <= a_opcode;
        a_size_q <= a_size;
        a_src_q  <= a_source;
        a_addr_q <= a_address;
      end
      if (d_fire && d_first && d_hit && d_multi) begin
        d_op_q   <= d_opcode;
        d_size_q <= d_size;
        d_src_q  <= d_source;
      end
      st_q         <= a_valid & ~a_ready;
      st_op_q      <= a_opcode;
      st_param_q   <= a_param;
      st_size_q    <= a_size;
      st_src_q     <= a_source;
      st_addr_q    <= a_address;
      st_mask_q    <= a_mask;
      wd_cnt_q     <= wd_cnt_d;
      wd_fired_q   <= wd_fired_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_source_q <= err_source_d;
      err_sticky_q <= err_sticky_q | err_valid_d;
      err_count_q  <= err_count_d;
      inflight_q   <= inflight_d;
    end
  end

  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;
  assign err_source     = err_source_q;
  assign err_sticky     = err_sticky_q;
  assign err_count      = err_count_q;
  assign inflight_count = inflight_q;
endmodule
`default_nettype wire
